// File: rtl/mips_avalon_arbiter.sv
// Two-master (instruction fetch / data) to one-slave Avalon-MM arbiter with a
// sticky stall watchdog. The granted master's request is forwarded combinationally.
module mips_avalon_arbiter #(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        grant_data,
  output logic        timeout_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] STALL_LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] stall_ctr_q, stall_ctr_d;
  logic          timeout_error_q, timeout_error_d;

  logic ireq, dreq, i_done, d_done;

  assign ireq   = i_read;
  assign dreq   = d_read | d_write;
  assign i_done = (state_q == GNT_I) && ireq && !avm_waitrequest;
  assign d_done = (state_q == GNT_D) && dreq && !avm_waitrequest;

  assign i_waitrequest = !i_done;
  assign d_waitrequest = !d_done;
  assign i_readdata    = avm_readdata;
  assign d_readdata    = avm_readdata;
  assign grant_data    = (state_q == GNT_D);
  assign timeout_error = timeout_error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      last_grant_q    <= 1'b0;
      stall_ctr_q     <= '0;
      timeout_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      stall_ctr_q     <= stall_ctr_d;
      timeout_error_q <= timeout_error_d;
    end
  end

  // last_grant: 0 = instruction master, 1 = data master.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    stall_ctr_d     = stall_ctr_q;
    timeout_error_d = timeout_error_q;
    avm_address     = '0;
    avm_read        = 1'b0;
    avm_write       = 1'b0;
    avm_writedata   = '0;
    avm_byteenable  = '0;

    case (state_q)
      IDLE: begin
        stall_ctr_d = '0;
        if (ireq && dreq) begin
          state_d = (ROUND_ROBIN != 0 && last_grant_q) ? GNT_I : GNT_D;
        end else if (ireq) begin
          state_d = GNT_I;
        end else if (dreq) begin
          state_d = GNT_D;
        end
      end

      GNT_I: begin
        avm_address    = i_address;
        avm_read       = i_read;
        avm_byteenable = 4'hF;
        if (!ireq) begin
          state_d     = IDLE;
          stall_ctr_d = '0;
        end else if (!avm_waitrequest) begin
          last_grant_d = 1'b0;
          stall_ctr_d  = '0;
          state_d      = dreq ? GNT_D : IDLE;
        end else if (stall_ctr_q < STALL_LIMIT) begin
          stall_ctr_d = stall_ctr_q + 1'b1;
        end
      end

      GNT_D: begin
        avm_address    = d_address;
        avm_read       = d_read;
        avm_write      = d_write;
        avm_writedata  = d_writedata;
        avm_byteenable = d_byteenable;
        if (!dreq) begin
          state_d     = IDLE;
          stall_ctr_d = '0;
        end else if (!avm_waitrequest) begin
          last_grant_d = 1'b1;
          stall_ctr_d  = '0;
          state_d      = ireq ? GNT_I : IDLE;
        end else if (stall_ctr_q < STALL_LIMIT) begin
          stall_ctr_d = stall_ctr_q + 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        stall_ctr_d = '0;
      end
    endcase

    // The error flag rises on the same edge the counter reaches the limit.
    if (stall_ctr_d == STALL_LIMIT) begin
      timeout_error_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Bench for mips_avalon_arbiter: a directed vector table against two instances
// (round-robin and data-priority) plus multi-cycle sequences against a small RAM model.
module tb_mips_avalon_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_address = '0;
  logic        i_read = 1'b0;
  logic [31:0] d_address = '0;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_writedata = '0;
  logic [3:0]  d_byteenable = '0;

  logic        i_waitrequest, d_waitrequest, avm_read, avm_write, grant_data, timeout_error;
  logic [31:0] i_readdata, d_readdata, avm_address, avm_writedata, avm_readdata;
  logic [3:0]  avm_byteenable;

  logic        i_waitrequest2, d_waitrequest2, avm_read2, avm_write2, grant_data2, timeout_error2;
  logic [31:0] i_readdata2, d_readdata2, avm_address2, avm_writedata2;
  logic [3:0]  avm_byteenable2;

  logic        slaveMode = 1'b0;
  logic        forceStall = 1'b0;
  logic        tbWait = 1'b1;
  logic        slaveWait, avmWait1;
  logic [1:0]  waitCnt = '0;
  logic [31:0] dataMem [0:15] = '{default: 32'h0};

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mips_avalon_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avmWait1), .avm_readdata(avm_readdata),
    .grant_data(grant_data), .timeout_error(timeout_error)
  );

  mips_avalon_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(64)) dutNoRr (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest2), .i_readdata(i_readdata2),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest2), .d_readdata(d_readdata2),
    .avm_address(avm_address2), .avm_read(avm_read2), .avm_write(avm_write2),
    .avm_writedata(avm_writedata2), .avm_byteenable(avm_byteenable2),
    .avm_waitrequest(tbWait), .avm_readdata(avm_readdata),
    .grant_data(grant_data2), .timeout_error(timeout_error2)
  );

  // RAM model: two wait cycles per access, instruction words are 0x1000_0000 + index.
  assign slaveWait = forceStall || (waitCnt < 2'd2);
  assign avmWait1  = slaveMode ? slaveWait : tbWait;

  always_comb begin
    if (avm_address[31:28] == 4'hB) avm_readdata = 32'h1000_0000 + {28'h0, avm_address[5:2]};
    else                            avm_readdata = dataMem[avm_address[5:2]];
  end

  always @(posedge clk) begin
    if (!slaveMode || !(avm_read || avm_write)) begin
      waitCnt <= '0;
    end else if (slaveWait) begin
      if (waitCnt < 2'd2) waitCnt <= waitCnt + 2'd1;
    end else begin
      waitCnt <= '0;
      if (avm_write && avm_address[31:28] != 4'hB) begin
        for (int b = 0; b < 4; b++)
          if (avm_byteenable[b]) dataMem[avm_address[5:2]][8*b +: 8] <= avm_writedata[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic iRead, dRead, dWrite, avmWait;
    logic gd1, gd2, iWait, dWait, aRead, aWrite;
    logic [1:0] sel;
  } vec_t;

  vec_t vecs [15];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic iR, input logic dR, input logic dW, input logic [31:0] iA,
                               input logic [31:0] dA, input logic [31:0] wd, input logic [3:0] be);
    i_read = iR; d_read = dR; d_write = dW;
    i_address = iA; d_address = dA; d_writedata = wd; d_byteenable = be;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits for the selected master's completion cycle, sampling mid-cycle.
  task automatic waitDone(input logic isData, input string name);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (isData ? !d_waitrequest : !i_waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: no completion within 40 cycles, waitrequest got 1, expected 0", name);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,2'd1};
    vecs[3]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd1};
    vecs[4]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,2'd2};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd1};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,2'd2};
    vecs[8]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,2'd2};
    vecs[9]  = '{1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0};
    vecs[10] = '{1'b1,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,2'd1};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,2'd1};
    vecs[12] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,2'd0};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,2'd2};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0};

    resetDut();
    #1;
    checkOutput("reset i_waitrequest", {31'h0, i_waitrequest}, 32'h1);
    checkOutput("reset d_waitrequest", {31'h0, d_waitrequest}, 32'h1);
    checkOutput("reset avm strobes", {30'h0, avm_read, avm_write}, 32'h0);
    checkOutput("reset avm_address", avm_address, 32'h0);
    checkOutput("reset avm_byteenable", {28'h0, avm_byteenable}, 32'h0);
    checkOutput("reset grant/timeout", {30'h0, grant_data, timeout_error}, 32'h0);

    // Table: fixed addresses, bench-driven slave waitrequest shared by both instances.
    for (int v = 0; v < 15; v++) begin
      logic [31:0] expAddr, expWd;
      logic [3:0]  expBe;
      @(negedge clk);
      applyStimulus(vecs[v].iRead, vecs[v].dRead, vecs[v].dWrite, 32'hBFC0_0000, 32'h4, 32'hDEAD_BEEF, 4'h3);
      tbWait = vecs[v].avmWait;
      #1;
      case (vecs[v].sel)
        2'd1:    begin expAddr = 32'hBFC0_0000; expBe = 4'hF; expWd = 32'h0; end
        2'd2:    begin expAddr = 32'h4; expBe = 4'h3; expWd = 32'hDEAD_BEEF; end
        default: begin expAddr = 32'h0; expBe = 4'h0; expWd = 32'h0; end
      endcase
      checkOutput($sformatf("vec%0d grant_data rr", v), {31'h0, grant_data}, {31'h0, vecs[v].gd1});
      checkOutput($sformatf("vec%0d grant_data fixed", v), {31'h0, grant_data2}, {31'h0, vecs[v].gd2});
      checkOutput($sformatf("vec%0d waitrequests", v), {30'h0, i_waitrequest, d_waitrequest},
                  {30'h0, vecs[v].iWait, vecs[v].dWait});
      checkOutput($sformatf("vec%0d avm strobes", v), {30'h0, avm_read, avm_write},
                  {30'h0, vecs[v].aRead, vecs[v].aWrite});
      checkOutput($sformatf("vec%0d avm_address", v), avm_address, expAddr);
      checkOutput($sformatf("vec%0d avm_byteenable", v), {28'h0, avm_byteenable}, {28'h0, expBe});
      checkOutput($sformatf("vec%0d avm_writedata", v), avm_writedata, expWd);
    end

    // Lone instruction read: one-cycle grant latency, one-cycle completion.
    slaveMode = 1'b1;
    tbWait = 1'b1;
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hBFC0_0000, 32'h0, 32'h0, 4'h0);
    #1;
    checkOutput("t1 no grant yet", {31'h0, avm_read}, 32'h0);
    @(negedge clk); #1;
    checkOutput("t1 granted", {30'h0, avm_read, grant_data}, 32'h2);
    waitDone(1'b0, "t1 completion");
    checkOutput("t1 readdata", i_readdata, 32'h1000_0000);
    checkOutput("t1 d_waitrequest", {31'h0, d_waitrequest}, 32'h1);
    @(posedge clk); #1;
    checkOutput("t1 waitrequest back high", {31'h0, i_waitrequest}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);

    // Simultaneous write and fetch: data first, fetch granted at the data completion edge.
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hBFC0_0004, 32'h4, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk); #1;
    checkOutput("t2 data granted", {30'h0, grant_data, avm_write}, 32'h3);
    waitDone(1'b1, "t2 write completion");
    checkOutput("t2 fetch stalled", {31'h0, i_waitrequest}, 32'h1);
    @(posedge clk); #1;
    d_write = 1'b0;
    #1;
    checkOutput("t2 direct handover", {30'h0, grant_data, avm_read}, 32'h1);
    checkOutput("t2 fetch address", avm_address, 32'hBFC0_0004);
    waitDone(1'b0, "t2 fetch completion");
    checkOutput("t2 fetch data", i_readdata, 32'h1000_0001);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h4, 32'h0, 4'hF);
    waitDone(1'b1, "t2 readback completion");
    checkOutput("t2 readback", d_readdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);

    // Continuous contention, round robin: last grant was data, so order is I,D,I,D.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hBFC0_0008, 32'h4, 32'h0, 4'hF);
    for (int t = 0; t < 4; t++) begin
      logic [31:0] gotGrant;
      gotGrant = 32'hFFFF_FFFF;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk); #1;
        if (!i_waitrequest || !d_waitrequest) begin
          gotGrant = {31'h0, grant_data};
          break;
        end
      end
      checkOutput($sformatf("t3 grant order %0d", t), gotGrant, (t % 2 == 0) ? 32'h0 : 32'h1);
      if (t == 3) applyStimulus(1'b1, 1'b0, 1'b0, 32'hBFC0_0008, 32'h4, 32'h0, 4'hF);
    end
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    #1;
    checkOutput("t3 back to idle", {30'h0, grant_data, avm_read}, 32'h0);

    // Byte-lane write: only byte 1 of word 1 changes.
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h4, 32'h0000_AB00, 4'b0010);
    waitDone(1'b1, "t4 write completion");
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);

    // Watchdog: 70 stall cycles, error after the 64th, sticky afterwards.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h4, 32'h0, 4'hF);
    forceStall = 1'b1;
    @(negedge clk); #1;
    checkOutput("t5 granted", {31'h0, grant_data}, 32'h1);
    repeat (63) @(negedge clk);
    #1;
    checkOutput("t5 no timeout at 63", {31'h0, timeout_error}, 32'h0);
    @(negedge clk); #1;
    checkOutput("t5 timeout at 64", {31'h0, timeout_error}, 32'h1);
    repeat (6) @(negedge clk);
    forceStall = 1'b0;
    #1;
    checkOutput("t5 completes", {31'h0, d_waitrequest}, 32'h0);
    checkOutput("t5 byte-lane result", d_readdata, 32'hDEAD_ABEF);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    @(negedge clk); #1;
    checkOutput("t5 timeout sticky", {30'h0, timeout_error, grant_data}, 32'h2);

    // Reset during a data write, with a fetch pending.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h8, 32'h1234_5678, 4'hF);
    @(negedge clk); #1;
    checkOutput("t6 write in flight", {30'h0, grant_data, avm_write}, 32'h3);
    i_read = 1'b1;
    i_address = 32'hBFC0_0008;
    reset = 1'b1;
    #1;
    checkOutput("t6 strobe drops", {31'h0, avm_write}, 32'h0);
    checkOutput("t6 cleared", {29'h0, grant_data, timeout_error, i_waitrequest}, 32'h1);
    d_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("t6 idle after reset", {31'h0, avm_read}, 32'h0);
    @(negedge clk); #1;
    checkOutput("t6 fetch regranted", {30'h0, avm_read, grant_data}, 32'h2);
    checkOutput("t6 fetch address", avm_address, 32'hBFC0_0008);
    waitDone(1'b0, "t6 fetch completion");
    checkOutput("t6 fetch data", i_readdata, 32'h1000_0002);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    checkOutput("t6 data word untouched", dataMem[2], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
